// File: rtl/rvv_backend_vrf_wr_arb.sv
// Retire-to-VRF write arbiter: accepts an in-order prefix of retiring uops (max NUM_WR_PORT distinct vd),
// merges same-vd writes byte-wise (younger wins) and drives registered full-width per-register buses.
module rvv_backend_vrf_wr_arb #(
    parameter int VLEN        = 128,
    parameter int NUM_RT_UOP  = 4,
    parameter int NUM_WR_PORT = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_RT_UOP-1:0]        rt_valid_i,
    input  logic [NUM_RT_UOP*5-1:0]      rt_vd_i,
    input  logic [NUM_RT_UOP*VLEN-1:0]   rt_data_i,
    input  logic [NUM_RT_UOP*VLEN/8-1:0] rt_strb_i,
    input  logic [NUM_RT_UOP-1:0]        rt_last_uop_i,
    output logic [NUM_RT_UOP-1:0]        rt_ready_o,
    input  logic                         vrf_wr_stall_i,
    input  logic                         flush_i,
    output logic [32*VLEN-1:0]           vrf_wr_wen_full_o,
    output logic [32*VLEN-1:0]           vrf_wr_data_full_o,
    output logic [15:0]                  rt_cnt_o,
    output logic                         rt_last_done_o
);
    localparam int VLENB = VLEN / 8;

    logic [NUM_RT_UOP-1:0]   acc;
    logic [31:0][VLEN-1:0]   wen_d, wen_q;
    logic [31:0][VLEN-1:0]   data_d, data_q;
    logic [15:0]             cnt_inc;
    logic [15:0]             rt_cnt_q;
    logic                    last_d, last_q;

    // Prefix scan: a slot that repeats an already-accepted vd never costs a new port.
    always_comb begin
        logic [NUM_RT_UOP-1:0] a;
        logic                  stop;
        logic                  hit;
        int                    n_vd;
        a    = '0;
        stop = 1'b0;
        n_vd = 0;
        for (int i = 0; i < NUM_RT_UOP; i++) begin
            hit = 1'b0;
            for (int j = 0; j < i; j++) begin
                if (a[j] && (rt_vd_i[j*5 +: 5] == rt_vd_i[i*5 +: 5])) hit = 1'b1;
            end
            if (!stop) begin
                if (!rt_valid_i[i] || (!hit && (n_vd == NUM_WR_PORT))) begin
                    stop = 1'b1;
                end else begin
                    a[i] = 1'b1;
                    if (!hit) n_vd = n_vd + 1;
                end
            end
        end
        if (vrf_wr_stall_i || flush_i || !rst_n) a = '0;
        acc = a;
    end

    assign rt_ready_o = acc;

    // Later slots overwrite earlier ones, so the younger uop wins on overlapping bytes.
    always_comb begin
        wen_d   = '0;
        data_d  = '0;
        cnt_inc = '0;
        last_d  = 1'b0;
        for (int i = 0; i < NUM_RT_UOP; i++) begin
            if (acc[i]) begin
                cnt_inc = cnt_inc + 16'd1;
                if (rt_last_uop_i[i]) last_d = 1'b1;
                for (int b = 0; b < VLENB; b++) begin
                    if (rt_strb_i[i*VLENB + b]) begin
                        wen_d[rt_vd_i[i*5 +: 5]][b*8 +: 8]  = 8'hFF;
                        data_d[rt_vd_i[i*5 +: 5]][b*8 +: 8] = rt_data_i[i*VLEN + b*8 +: 8];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wen_q    <= '0;
            data_q   <= '0;
            rt_cnt_q <= '0;
            last_q   <= 1'b0;
        end else begin
            wen_q    <= wen_d;
            data_q   <= data_d;
            rt_cnt_q <= rt_cnt_q + cnt_inc;
            last_q   <= last_d;
        end
    end

    assign vrf_wr_wen_full_o  = wen_q;
    assign vrf_wr_data_full_o = data_q;
    assign rt_cnt_o           = rt_cnt_q;
    assign rt_last_done_o     = last_q;

endmodule

// File: tb/tb_rvv_backend_vrf_wr_arb.sv
// Bench for rvv_backend_vrf_wr_arb: byte-level reference model checked every cycle,
// plus directed vectors with literal expectations.
module tb_rvv_backend_vrf_wr_arb;
    localparam int VLEN = 128;
    localparam int NRT  = 4;
    localparam int NWP  = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [3:0]       valid, last;
    logic [19:0]      vd;
    logic [511:0]     data;
    logic [63:0]      strb;
    logic             stall, flush;
    logic [3:0]       ready;
    logic [4095:0]    wen_full, data_full;
    logic [15:0]      cnt;
    logic             last_done;

    int n_cmp = 0;
    int n_err = 0;

    rvv_backend_vrf_wr_arb #(.VLEN(VLEN), .NUM_RT_UOP(NRT), .NUM_WR_PORT(NWP)) dut (
        .clk(clk), .rst_n(rst_n),
        .rt_valid_i(valid), .rt_vd_i(vd), .rt_data_i(data), .rt_strb_i(strb),
        .rt_last_uop_i(last), .rt_ready_o(ready),
        .vrf_wr_stall_i(stall), .flush_i(flush),
        .vrf_wr_wen_full_o(wen_full), .vrf_wr_data_full_o(data_full),
        .rt_cnt_o(cnt), .rt_last_done_o(last_done)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string nm, input int idx, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d] act=%h exp=%h", nm, idx, act, exp);
        end
    endtask

    // Acceptance rule: in-order prefix of valid slots, at most NWP distinct vd.
    function automatic logic [3:0] model_ready(input logic [3:0] v, input logic [19:0] d,
                                               input logic st, input logic fl, input logic rn);
        int         seen[$];
        logic [3:0] r;
        r = '0;
        if (!rn || st || fl) return r;
        for (int i = 0; i < 4; i++) begin
            bit known;
            if (!v[i]) break;
            known = 0;
            foreach (seen[k]) if (seen[k] == int'(d[i*5 +: 5])) known = 1;
            if (!known) begin
                if (seen.size() == NWP) break;
                seen.push_back(int'(d[i*5 +: 5]));
            end
            r[i] = 1'b1;
        end
        return r;
    endfunction

    logic [127:0] exp_wen [32];
    logic [127:0] exp_dat [32];
    logic [15:0]  exp_cnt;
    logic         exp_last;

    always @(posedge clk or negedge rst_n) begin
        logic [3:0] r;
        if (!rst_n) begin
            for (int k = 0; k < 32; k++) begin exp_wen[k] = '0; exp_dat[k] = '0; end
            exp_cnt  = '0;
            exp_last = 1'b0;
        end else begin
            r = model_ready(valid, vd, stall, flush, rst_n);
            for (int k = 0; k < 32; k++) begin exp_wen[k] = '0; exp_dat[k] = '0; end
            exp_last = 1'b0;
            for (int s = 0; s < 4; s++) begin
                if (r[s]) begin
                    exp_cnt = exp_cnt + 16'd1;
                    if (last[s]) exp_last = 1'b1;
                    for (int b = 0; b < 16; b++) begin
                        if (strb[s*16 + b]) begin
                            exp_wen[vd[s*5 +: 5]][b*8 +: 8] = 8'hFF;
                            exp_dat[vd[s*5 +: 5]][b*8 +: 8] = data[s*VLEN + b*8 +: 8];
                        end
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        int nreg;
        nreg = 0;
        chk("ready", 0, 128'(ready), 128'(model_ready(valid, vd, stall, flush, rst_n)));
        for (int r = 0; r < 32; r++) begin
            chk("wen", r, wen_full[r*VLEN +: VLEN], exp_wen[r]);
            chk("data", r, data_full[r*VLEN +: VLEN], exp_dat[r]);
            if (|wen_full[r*VLEN +: VLEN]) nreg++;
        end
        chk("cnt", 0, 128'(cnt), 128'(exp_cnt));
        chk("last_done", 0, 128'(last_done), 128'(exp_last));
        chk("port_limit_ok", 0, 128'(nreg <= NWP), 128'd1);
    end

    task automatic clr_in();
        valid = '0; last = '0; vd = '0; data = '0; strb = '0;
    endtask

    task automatic set_slot(input int s, input logic [4:0] d, input logic [7:0] fb,
                            input logic [15:0] sb, input logic l);
        valid[s]             = 1'b1;
        vd[s*5 +: 5]         = d;
        data[s*VLEN +: VLEN] = {16{fb}};
        strb[s*16 +: 16]     = sb;
        last[s]              = l;
    endtask

    function automatic logic [127:0] wreg(input int r);
        return wen_full[r*VLEN +: VLEN];
    endfunction

    function automatic logic [127:0] dreg(input int r);
        return data_full[r*VLEN +: VLEN];
    endfunction

    task automatic rand_slots();
        for (int w = 0; w < 16; w++) data[w*32 +: 32] = $urandom;
        strb[31:0]  = $urandom;
        strb[63:32] = $urandom;
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
        clr_in();
        set_slot(0, 5'd3, 8'hA5, 16'hFFFF, 1'b1);
        repeat (2) @(posedge clk);
        #2;
        chk("rst_ready", 0, 128'(ready), 128'd0);
        chk("rst_wen_any", 0, 128'(|wen_full), 128'd0);
        chk("rst_cnt", 0, 128'(cnt), 128'd0);
        chk("rst_last", 0, 128'(last_done), 128'd0);
        #2 rst_n = 1'b1;
        clr_in();

        // Single write
        @(posedge clk); #1;
        set_slot(0, 5'd3, 8'hA5, 16'hFFFF, 1'b0);
        #1 chk("t1_ready", 0, 128'(ready), 128'b0001);
        @(posedge clk); #1; clr_in(); #1;
        chk("t1_wen3", 3, wreg(3), {128{1'b1}});
        chk("t1_dat3", 3, dreg(3), {16{8'hA5}});
        chk("t1_wen2", 2, wreg(2), 128'd0);
        chk("t1_cnt", 0, 128'(cnt), 128'd1);

        // Merge on vd 5, younger slot wins bytes 4-7
        @(posedge clk); #1;
        set_slot(0, 5'd5, 8'h11, 16'h00FF, 1'b0);
        set_slot(1, 5'd5, 8'h22, 16'h0FF0, 1'b0);
        #1 chk("t2_ready", 0, 128'(ready), 128'b0011);
        @(posedge clk); #1; clr_in(); #1;
        chk("t2_wen5", 5, wreg(5), 128'h00000000_FFFFFFFF_FFFFFFFF_FFFFFFFF);
        chk("t2_dat5", 5, dreg(5), 128'h00000000_22222222_22222222_11111111);
        chk("t2_cnt", 0, 128'(cnt), 128'd3);

        // Port limit: vd 1,2,2,7
        @(posedge clk); #1;
        set_slot(0, 5'd1, 8'h01, 16'hFFFF, 1'b0);
        set_slot(1, 5'd2, 8'h02, 16'hFFFF, 1'b0);
        set_slot(2, 5'd2, 8'h03, 16'h000F, 1'b0);
        set_slot(3, 5'd7, 8'h07, 16'hFFFF, 1'b0);
        #1 chk("t3_ready", 0, 128'(ready), 128'b0111);
        @(posedge clk); #1; clr_in(); #1;
        chk("t3_wen1", 1, wreg(1), {128{1'b1}});
        chk("t3_dat2", 2, dreg(2), {{12{8'h02}}, {4{8'h03}}});
        chk("t3_wen7", 7, wreg(7), 128'd0);
        chk("t3_cnt", 0, 128'(cnt), 128'd6);

        // Gap in valid
        @(posedge clk); #1;
        set_slot(0, 5'd8, 8'h08, 16'hFFFF, 1'b0);
        set_slot(2, 5'd9, 8'h09, 16'hFFFF, 1'b0);
        set_slot(3, 5'd9, 8'h09, 16'hFFFF, 1'b0);
        #1 chk("t4_ready", 0, 128'(ready), 128'b0001);
        @(posedge clk); #1; clr_in(); #1;
        chk("t4_wen9", 9, wreg(9), 128'd0);
        chk("t4_cnt", 0, 128'(cnt), 128'd7);

        // Stall blocks everything
        @(posedge clk); #1;
        for (int s = 0; s < 4; s++) set_slot(s, 5'(s), 8'h44, 16'hFFFF, 1'b1);
        stall = 1'b1;
        #1 chk("t5_ready", 0, 128'(ready), 128'd0);
        @(posedge clk); #1; clr_in(); stall = 1'b0; #1;
        chk("t5_wen_any", 0, 128'(|wen_full), 128'd0);
        chk("t5_cnt", 0, 128'(cnt), 128'd7);

        // Accept with last_uop, then flush: registered write survives
        @(posedge clk); #1;
        set_slot(0, 5'd9, 8'h99, 16'hFFFF, 1'b1);
        #1 chk("t6_ready", 0, 128'(ready), 128'b0001);
        @(posedge clk); #1;
        clr_in();
        for (int s = 0; s < 4; s++) set_slot(s, 5'd10, 8'hAA, 16'hFFFF, 1'b1);
        flush = 1'b1;
        #1;
        chk("t6_flush_ready", 0, 128'(ready), 128'd0);
        chk("t6_wen9", 9, wreg(9), {128{1'b1}});
        chk("t6_last", 0, 128'(last_done), 128'd1);
        chk("t6_cnt", 0, 128'(cnt), 128'd8);
        @(posedge clk); #1; clr_in(); flush = 1'b0; #1;
        chk("t6_wen_any", 0, 128'(|wen_full), 128'd0);
        chk("t6_last_pulse", 0, 128'(last_done), 128'd0);
        chk("t6_cnt2", 0, 128'(cnt), 128'd8);

        // Zero-strobe slot still consumes a port
        @(posedge clk); #1;
        set_slot(0, 5'd4, 8'h44, 16'h0000, 1'b0);
        set_slot(1, 5'd6, 8'h3C, 16'hFFFF, 1'b0);
        set_slot(2, 5'd8, 8'h88, 16'hFFFF, 1'b0);
        #1 chk("t7_ready", 0, 128'(ready), 128'b0011);
        @(posedge clk); #1; clr_in(); #1;
        chk("t7_wen4", 4, wreg(4), 128'd0);
        chk("t7_dat6", 6, dreg(6), {16{8'h3C}});
        chk("t7_cnt", 0, 128'(cnt), 128'd10);

        // Stall and flush together
        @(posedge clk); #1;
        set_slot(0, 5'd1, 8'h55, 16'hFFFF, 1'b1);
        stall = 1'b1; flush = 1'b1;
        #1 chk("t8_ready", 0, 128'(ready), 128'd0);
        @(posedge clk); #1; clr_in(); stall = 1'b0; flush = 1'b0; #1;
        chk("t8_cnt", 0, 128'(cnt), 128'd10);

        // Random traffic over a small vd set
        for (int k = 0; k < 300; k++) begin
            @(posedge clk); #1;
            clr_in();
            valid = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) != 0) valid[0] = 1'b1;
            for (int s = 0; s < 4; s++) vd[s*5 +: 5] = 5'($urandom_range(0, 3));
            last  = 4'($urandom_range(0, 15));
            rand_slots();
            stall = ($urandom_range(0, 9) == 0);
            flush = ($urandom_range(0, 14) == 0);
        end
        @(posedge clk); #1; clr_in(); stall = 1'b0; flush = 1'b0;

        // Counter wrap from a fresh reset
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        for (int k = 0; k < 16385; k++) begin
            @(posedge clk); #1;
            set_slot(0, 5'd1, 8'h00, 16'h0000, 1'b0);
            set_slot(1, 5'd1, 8'h00, 16'h0000, 1'b0);
            set_slot(2, 5'd2, 8'h00, 16'h0000, 1'b0);
            set_slot(3, 5'd2, 8'h00, 16'h0000, 1'b0);
            rand_slots();
        end
        @(posedge clk); #1; clr_in(); #1;
        chk("wrap_cnt", 0, 128'(cnt), 128'd4);

        // Async reset mid-burst
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            set_slot(0, 5'd11, 8'h00, 16'h0000, 1'b1);
            set_slot(1, 5'd12, 8'h00, 16'h0000, 1'b1);
            rand_slots();
        end
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("arst_wen_any", 0, 128'(|wen_full), 128'd0);
        chk("arst_cnt", 0, 128'(cnt), 128'd0);
        chk("arst_last", 0, 128'(last_done), 128'd0);
        chk("arst_ready", 0, 128'(ready), 128'd0);
        @(posedge clk); #3;
        clr_in();
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        chk("post_cnt", 0, 128'(cnt), 128'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
